cmpact_writer: RTL and testbench
================================

// Module: cmpact_writer
// PURPOSE
//  Sparse-activation compressor: the write side of the GBF activation/flag buffers, feeding the
//  activation distributor's read path. Accepts one dense block of NUM_DATA activations, writes a
//  NUM_DATA-bit nonzero-flag word to GBFFLGACT, then the nonzero values (ascending index, one per
//  cycle) to GBFACT. Sits between the PE-array output/pool stage and the activation GBFs.
// PARAMETERS
//  NUM_DATA        32  activations per block (= flag word width)
//  DATA_WIDTH      8   bits per activation
//  ACT_ADDRWIDTH   10  GBFACT write-address width
//  FLG_ADDRWIDTH   6   GBFFLGACT write-address width
// PORTS
//  clk               in   1                    clock, all logic on rising edge
//  rst_n             in   1                    asynchronous active-low reset
//  CTRL_ClrAddr      in   1                    clear both write pointers to 0 (honoured in IDLE only)
//  POOL_ValAct       in   1                    dense block valid
//  CMPACT_RdyAct     out  1                    block accept ready; transfer when Val && Rdy
//  POOL_Act          in   NUM_DATA*DATA_WIDTH  dense block; element i = bits [i*DATA_WIDTH +: DATA_WIDTH]
//  GBFFLGACT_Rdy     in   1                    flag buffer can take a write this cycle
//  GBFFLGACT_EnWr    out  1                    flag write strobe
//  GBFFLGACT_AddrWr  out  FLG_ADDRWIDTH        flag write address (pointer register)
//  GBFFLGACT_DatWr   out  NUM_DATA             flag word; bit i = element i nonzero
//  GBFACT_Rdy        in   1                    act buffer can take a write this cycle
//  GBFACT_EnWr       out  1                    act write strobe
//  GBFACT_AddrWr     out  ACT_ADDRWIDTH        act write address (pointer register)
//  GBFACT_DatWr      out  DATA_WIDTH           nonzero activation value
// BEHAVIOUR
//  Reset: state IDLE; CMPACT_RdyAct=1 out of reset; both EnWr=0; both AddrWr=0; DatWr outputs 0;
//   block/mask registers 0. Reset mid-block aborts it; partial writes are not rolled back.
//  FSM: IDLE -> WRFLG on accept; WRFLG -> IDLE if flag word==0, else WRACT, on the flag write;
//   WRACT -> IDLE on the write that clears the last mask bit. CMPACT_RdyAct = (state==IDLE).
//  Accept (cycle t): latch POOL_Act; flag[i] = |element i; mask <= flag.
//  WRFLG: GBFFLGACT_EnWr = GBFFLGACT_Rdy (combinational), DatWr = latched flag; on the strobe the
//   flag pointer increments. Earliest flag write t+1; stalls while Rdy=0.
//  WRACT: GBFACT_EnWr = GBFACT_Rdy; DatWr = element at lowest set mask bit (priority encoder);
//   on the strobe clear that bit and increment act pointer. Earliest act writes t+2..t+1+popcount.
//  Throughput, no backpressure: one block per popcount+2 cycles (2 cycles for an all-zero block).
//  Popcount held in a $clog2(NUM_DATA)+1-bit register (32 must be representable).
//  Pointers wrap modulo 2^width silently; no full detection here (owned by GBF Rdy).
//  CTRL_ClrAddr ignored outside IDLE. In IDLE with POOL_ValAct same cycle: pointers cleared AND
//   block accepted; its flag write goes to address 0.
//  Flag word written strictly before the block's first act value; act order ascending index.
// CONFIGURATION
//  CMPACT_RELU_EN defined: element treated as signed; negative values forced to 0 before flag
//   generation (flag bit 0, value not written); positive values written unchanged.
//  CMPACT_RELU_EN undefined: any nonzero bit pattern (incl. negative) is flagged and written as-is.
// TESTING
//  All-zero block, both Rdy=1 -> one flag write 32'h0 at addr 0, no GBFACT_EnWr, RdyAct back at t+2.
//  Elements 0=8'h11,5=8'h22,31=8'h33 rest 0 -> flag 32'h8000_0021; act writes 11,22,33 at addr 0,1,2 on t+2..t+4.
//  Full block values 1..32, GBFACT_Rdy toggled 1/0 -> 32 writes in order, no drop/dup, addr 0..31, RdyAct low throughout.
//  Act pointer preset near 2^ACT_ADDRWIDTH-1 via writes, then 3-nonzero block -> addresses wrap ..3FE,3FF,000.
//  ClrAddr+ValAct same IDLE cycle after prior blocks -> flag addr 0, act addr 0; ClrAddr in WRACT ignored.
//  Element 3=8'hF0 (others 0): RELU_EN -> flag 0, no act write; undefined -> flag 32'h8, writes F0. rst_n low mid-WRACT -> IDLE, addrs 0.

Source files
------------

// File: rtl/cmpact_writer.sv
// Sparse-activation compressor: writes a nonzero-flag word, then the nonzero values in ascending index order.
// Optional build macro CMPACT_RELU_EN clamps negative activations to zero before flag generation.
module cmpact_writer #(
    parameter int NUM_DATA      = 32,
    parameter int DATA_WIDTH    = 8,
    parameter int ACT_ADDRWIDTH = 10,
    parameter int FLG_ADDRWIDTH = 6
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           CTRL_ClrAddr,
    input  logic                           POOL_ValAct,
    output logic                           CMPACT_RdyAct,
    input  logic [NUM_DATA*DATA_WIDTH-1:0] POOL_Act,
    input  logic                           GBFFLGACT_Rdy,
    output logic                           GBFFLGACT_EnWr,
    output logic [FLG_ADDRWIDTH-1:0]       GBFFLGACT_AddrWr,
    output logic [NUM_DATA-1:0]            GBFFLGACT_DatWr,
    input  logic                           GBFACT_Rdy,
    output logic                           GBFACT_EnWr,
    output logic [ACT_ADDRWIDTH-1:0]       GBFACT_AddrWr,
    output logic [DATA_WIDTH-1:0]          GBFACT_DatWr
);

    localparam int CNT_W = $clog2(NUM_DATA) + 1;

    typedef enum logic [1:0] {
        IDLE,
        WRFLG,
        WRACT
    } state_t;

    state_t                         state_q, state_d;
    logic [NUM_DATA*DATA_WIDTH-1:0] block_q, block_d;
    logic [NUM_DATA-1:0]            flag_q, flag_d;
    logic [NUM_DATA-1:0]            mask_q, mask_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [FLG_ADDRWIDTH-1:0]       flgPtr_q, flgPtr_d;
    logic [ACT_ADDRWIDTH-1:0]       actPtr_q, actPtr_d;

    logic [NUM_DATA*DATA_WIDTH-1:0] inBlock;
    logic [NUM_DATA-1:0]            inFlag;
    logic [CNT_W-1:0]               inCnt;
    logic [DATA_WIDTH-1:0]          actVal;

    // Incoming block conditioning: optional clamp, per-element flag and popcount.
    always_comb begin
        inBlock = POOL_Act;
        inFlag  = '0;
        inCnt   = '0;
        for (int i = 0; i < NUM_DATA; i++) begin
`ifdef CMPACT_RELU_EN
            if (POOL_Act[i*DATA_WIDTH + DATA_WIDTH-1]) begin
                inBlock[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
`endif
            inFlag[i] = |inBlock[i*DATA_WIDTH +: DATA_WIDTH];
            inCnt     = inCnt + CNT_W'(inFlag[i]);
        end
    end

    // Lowest set mask bit wins, so values leave in ascending index order.
    always_comb begin
        actVal = '0;
        for (int i = NUM_DATA-1; i >= 0; i--) begin
            if (mask_q[i]) begin
                actVal = block_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        block_d        = block_q;
        flag_d         = flag_q;
        mask_d         = mask_q;
        cnt_d          = cnt_q;
        flgPtr_d       = flgPtr_q;
        actPtr_d       = actPtr_q;
        GBFFLGACT_EnWr = 1'b0;
        GBFACT_EnWr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (CTRL_ClrAddr) begin
                    flgPtr_d = '0;
                    actPtr_d = '0;
                end
                if (POOL_ValAct) begin
                    block_d = inBlock;
                    flag_d  = inFlag;
                    mask_d  = inFlag;
                    cnt_d   = inCnt;
                    state_d = WRFLG;
                end
            end
            WRFLG: begin
                GBFFLGACT_EnWr = GBFFLGACT_Rdy;
                if (GBFFLGACT_Rdy) begin
                    flgPtr_d = flgPtr_q + FLG_ADDRWIDTH'(1);
                    state_d  = (flag_q == '0) ? IDLE : WRACT;
                end
            end
            WRACT: begin
                GBFACT_EnWr = GBFACT_Rdy;
                if (GBFACT_Rdy) begin
                    mask_d   = mask_q & (mask_q - NUM_DATA'(1));
                    actPtr_d = actPtr_q + ACT_ADDRWIDTH'(1);
                    cnt_d    = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            block_q  <= '0;
            flag_q   <= '0;
            mask_q   <= '0;
            cnt_q    <= '0;
            flgPtr_q <= '0;
            actPtr_q <= '0;
        end else begin
            state_q  <= state_d;
            block_q  <= block_d;
            flag_q   <= flag_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            flgPtr_q <= flgPtr_d;
            actPtr_q <= actPtr_d;
        end
    end

    assign CMPACT_RdyAct    = (state_q == IDLE);
    assign GBFFLGACT_AddrWr = flgPtr_q;
    assign GBFFLGACT_DatWr  = flag_q;
    assign GBFACT_AddrWr    = actPtr_q;
    assign GBFACT_DatWr     = actVal;

endmodule

// File: tb/tb_cmpact_writer.sv
// Self-checking bench for cmpact_writer: vector table, timing sequences and random blocks vs a queue-based model.
module tb_cmpact_writer;

    localparam int ND = 32;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam int FW = 6;
    localparam int BW = ND*DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          CTRL_ClrAddr = 1'b0;
    logic          POOL_ValAct = 1'b0;
    logic          CMPACT_RdyAct;
    logic [BW-1:0] POOL_Act = '0;
    logic          GBFFLGACT_Rdy = 1'b1;
    logic          GBFFLGACT_EnWr;
    logic [FW-1:0] GBFFLGACT_AddrWr;
    logic [ND-1:0] GBFFLGACT_DatWr;
    logic          GBFACT_Rdy = 1'b1;
    logic          GBFACT_EnWr;
    logic [AW-1:0] GBFACT_AddrWr;
    logic [DW-1:0] GBFACT_DatWr;

    cmpact_writer #(
        .NUM_DATA(ND), .DATA_WIDTH(DW), .ACT_ADDRWIDTH(AW), .FLG_ADDRWIDTH(FW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .CTRL_ClrAddr(CTRL_ClrAddr), .POOL_ValAct(POOL_ValAct),
        .CMPACT_RdyAct(CMPACT_RdyAct), .POOL_Act(POOL_Act),
        .GBFFLGACT_Rdy(GBFFLGACT_Rdy), .GBFFLGACT_EnWr(GBFFLGACT_EnWr),
        .GBFFLGACT_AddrWr(GBFFLGACT_AddrWr), .GBFFLGACT_DatWr(GBFFLGACT_DatWr),
        .GBFACT_Rdy(GBFACT_Rdy), .GBFACT_EnWr(GBFACT_EnWr),
        .GBFACT_AddrWr(GBFACT_AddrWr), .GBFACT_DatWr(GBFACT_DatWr)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [FW-1:0] addr;
        logic [ND-1:0] data;
        int            id;
    } flgExp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            id;
    } actExp_t;

    typedef struct {
        string         name;
        logic [BW-1:0] blk;
        logic [ND-1:0] expFlag;
        int            expCnt;
    } vec_t;

    flgExp_t flgQ[$];
    actExp_t actQ[$];

    int            checks = 0;
    int            errors = 0;
    int            rdyMode = 0;
    int            blkId = 0;
    logic [FW-1:0] mFlgPtr = '0;
    logic [AW-1:0] mActPtr = '0;

    int            lastFlagId = -1;
    logic [ND-1:0] lastFlagData = '0;
    logic [FW-1:0] lastFlagAddr = '0;
    int unsigned   flagCyc = 0;
    int unsigned   actFirstCyc = 0;
    int unsigned   actLastCyc = 0;
    int unsigned   acceptCyc = 0;
    int            actWrites = 0;
    int            actInBlk = 0;
    logic [AW-1:0] firstActAddr = '0;
    logic [AW-1:0] lastActAddr = '0;

    task automatic checkOutput(input string nm, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", nm, actual, expected);
        end
    endtask

    task automatic failNow(input string nm);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=event expected=none", nm);
    endtask

    // Write-port monitor: every strobe must match the next model entry.
    task automatic monitor();
        flgExp_t f;
        actExp_t a;
        if (GBFFLGACT_EnWr) begin
            checkOutput("flg_en_needs_rdy", 64'(GBFFLGACT_Rdy), 64'd1);
            checkOutput("rdyact_busy_flg", 64'(CMPACT_RdyAct), 64'd0);
            if (flgQ.size() == 0) begin
                failNow("unexpected_flag_write");
            end else begin
                f = flgQ.pop_front();
                checkOutput("flg_addr", 64'(GBFFLGACT_AddrWr), 64'(f.addr));
                checkOutput("flg_data", 64'(GBFFLGACT_DatWr), 64'(f.data));
                lastFlagId = f.id;
            end
            lastFlagData = GBFFLGACT_DatWr;
            lastFlagAddr = GBFFLGACT_AddrWr;
            flagCyc = cyc + 1;
        end
        if (GBFACT_EnWr) begin
            checkOutput("act_en_needs_rdy", 64'(GBFACT_Rdy), 64'd1);
            checkOutput("rdyact_busy_act", 64'(CMPACT_RdyAct), 64'd0);
            if (actQ.size() == 0) begin
                failNow("unexpected_act_write");
            end else begin
                a = actQ.pop_front();
                checkOutput("act_addr", 64'(GBFACT_AddrWr), 64'(a.addr));
                checkOutput("act_data", 64'(GBFACT_DatWr), 64'(a.data));
                checkOutput("act_after_flag", 64'(lastFlagId), 64'(a.id));
            end
            if (actInBlk == 0) begin
                actFirstCyc = cyc + 1;
                firstActAddr = GBFACT_AddrWr;
            end
            actLastCyc = cyc + 1;
            lastActAddr = GBFACT_AddrWr;
            actInBlk++;
            actWrites++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        case (rdyMode)
            1: begin
                GBFFLGACT_Rdy = ($urandom_range(0, 3) != 0);
                GBFACT_Rdy    = ($urandom_range(0, 3) != 0);
            end
            2: begin
                GBFFLGACT_Rdy = 1'b1;
                GBFACT_Rdy    = ~GBFACT_Rdy;
            end
            default: begin
                GBFFLGACT_Rdy = 1'b1;
                GBFACT_Rdy    = 1'b1;
            end
        endcase
        @(negedge clk);
        if (rst_n) monitor();
    endtask

    // Reference model: flag = nonzero (and non-negative when clamping), values in index order.
    task automatic modelBlock(input logic [BW-1:0] blk, input logic clr);
        logic [ND-1:0] flag;
        logic [DW-1:0] v;
        flag = '0;
        if (clr) begin
            mFlgPtr = '0;
            mActPtr = '0;
        end
        for (int i = 0; i < ND; i++) begin
            v = blk[i*DW +: DW];
`ifdef CMPACT_RELU_EN
            flag[i] = (v != 0) && !v[DW-1];
`else
            flag[i] = (v != 0);
`endif
        end
        flgQ.push_back('{addr: mFlgPtr, data: flag, id: blkId});
        mFlgPtr++;
        for (int i = 0; i < ND; i++) begin
            if (flag[i]) begin
                actQ.push_back('{addr: mActPtr, data: blk[i*DW +: DW], id: blkId});
                mActPtr++;
            end
        end
        blkId++;
    endtask

    task automatic applyStimulus(input logic [BW-1:0] blk, input logic clr);
        int n;
        n = 0;
        while (!CMPACT_RdyAct) begin
            if (n >= 2000) begin
                failNow("accept_timeout");
                break;
            end
            tick();
            n++;
        end
        modelBlock(blk, clr);
        actInBlk     = 0;
        POOL_Act     = blk;
        POOL_ValAct  = 1'b1;
        CTRL_ClrAddr = clr;
        tick();
        acceptCyc    = cyc;
        POOL_ValAct  = 1'b0;
        CTRL_ClrAddr = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (!CMPACT_RdyAct) begin
            if (n >= 2000) begin
                failNow("idle_timeout");
                break;
            end
            tick();
            n++;
        end
    endtask

    task automatic checkDrained(input string nm);
        checkOutput({nm, "_flgq_empty"}, 64'(flgQ.size()), 64'd0);
        checkOutput({nm, "_actq_empty"}, 64'(actQ.size()), 64'd0);
    endtask

    task automatic checkResetState();
        checkOutput("rst_rdyact", 64'(CMPACT_RdyAct), 64'd1);
        checkOutput("rst_flg_en", 64'(GBFFLGACT_EnWr), 64'd0);
        checkOutput("rst_act_en", 64'(GBFACT_EnWr), 64'd0);
        checkOutput("rst_flg_addr", 64'(GBFFLGACT_AddrWr), 64'd0);
        checkOutput("rst_act_addr", 64'(GBFACT_AddrWr), 64'd0);
        checkOutput("rst_flg_dat", 64'(GBFFLGACT_DatWr), 64'd0);
        checkOutput("rst_act_dat", 64'(GBFACT_DatWr), 64'd0);
    endtask

    task automatic enterReset();
        @(negedge clk);
        rst_n = 1'b0;
        flgQ.delete();
        actQ.delete();
        mFlgPtr = '0;
        mActPtr = '0;
        #1;
        checkResetState();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [BW-1:0] setElem(input logic [BW-1:0] b, input int idx, input logic [DW-1:0] v);
        logic [BW-1:0] r;
        r = b;
        r[idx*DW +: DW] = v;
        return r;
    endfunction

    logic [BW-1:0] zeroBlk, sparseBlk, negBlk, fullBlk, oddBlk, blk30, rndBlk;
    vec_t          vecs[5];
    int            base;

    initial begin
        zeroBlk   = '0;
        sparseBlk = setElem(setElem(setElem('0, 0, 8'h11), 5, 8'h22), 31, 8'h33);
        negBlk    = setElem('0, 3, 8'hF0);
        fullBlk   = '0;
        oddBlk    = '0;
        blk30     = '0;
        for (int i = 0; i < ND; i++) begin
            fullBlk = setElem(fullBlk, i, 8'(i + 1));
            if (i % 2 == 1) oddBlk = setElem(oddBlk, i, 8'(i));
            if (i < 30) blk30 = setElem(blk30, i, 8'(i + 1));
        end

        vecs[0] = '{name: "all_zero", blk: zeroBlk, expFlag: 32'h0000_0000, expCnt: 0};
        vecs[1] = '{name: "sparse3", blk: sparseBlk, expFlag: 32'h8000_0021, expCnt: 3};
`ifdef CMPACT_RELU_EN
        vecs[2] = '{name: "neg_elem3", blk: negBlk, expFlag: 32'h0000_0000, expCnt: 0};
`else
        vecs[2] = '{name: "neg_elem3", blk: negBlk, expFlag: 32'h0000_0008, expCnt: 1};
`endif
        vecs[3] = '{name: "full", blk: fullBlk, expFlag: 32'hFFFF_FFFF, expCnt: 32};
        vecs[4] = '{name: "odd_idx", blk: oddBlk, expFlag: 32'hAAAA_AAAA, expCnt: 16};

        repeat (2) @(negedge clk);
        #1;
        checkResetState();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("[TB] vector table");
        for (int v = 0; v < 5; v++) begin
            base = actWrites;
            applyStimulus(vecs[v].blk, 1'b0);
            waitIdle();
            checkOutput({vecs[v].name, "_flag"}, 64'(lastFlagData), 64'(vecs[v].expFlag));
            checkOutput({vecs[v].name, "_count"}, 64'(actWrites - base), 64'(vecs[v].expCnt));
            checkDrained(vecs[v].name);
        end

        $display("[TB] all-zero block timing");
        base = actWrites;
        applyStimulus(zeroBlk, 1'b1);
        checkOutput("zero_rdy_low_t", 64'(CMPACT_RdyAct), 64'd0);
        tick();
        checkOutput("zero_rdy_back_t2", 64'(CMPACT_RdyAct), 64'd1);
        checkOutput("zero_flag_cyc", 64'(flagCyc), 64'(acceptCyc + 1));
        checkOutput("zero_flag_addr", 64'(lastFlagAddr), 64'd0);
        checkOutput("zero_no_act", 64'(actWrites - base), 64'd0);

        $display("[TB] sparse block timing");
        applyStimulus(sparseBlk, 1'b1);
        waitIdle();
        checkOutput("sparse_flag_cyc", 64'(flagCyc), 64'(acceptCyc + 1));
        checkOutput("sparse_first_act_cyc", 64'(actFirstCyc), 64'(acceptCyc + 2));
        checkOutput("sparse_last_act_cyc", 64'(actLastCyc), 64'(acceptCyc + 4));
        checkOutput("sparse_last_addr", 64'(lastActAddr), 64'd2);

        $display("[TB] full block with toggling act ready");
        rdyMode = 2;
        base = actWrites;
        applyStimulus(fullBlk, 1'b1);
        waitIdle();
        checkOutput("toggle_count", 64'(actWrites - base), 64'd32);
        checkOutput("toggle_first_addr", 64'(firstActAddr), 64'd0);
        checkOutput("toggle_last_addr", 64'(lastActAddr), 64'd31);
        rdyMode = 0;

        $display("[TB] clear ignored while writing values");
        applyStimulus(fullBlk, 1'b0);
        tick();
        tick();
        CTRL_ClrAddr = 1'b1;
        repeat (3) tick();
        CTRL_ClrAddr = 1'b0;
        waitIdle();
        checkOutput("clr_ignored_act_ptr", 64'(GBFACT_AddrWr), 64'(mActPtr));
        checkOutput("clr_ignored_flg_ptr", 64'(GBFFLGACT_AddrWr), 64'(mFlgPtr));

        $display("[TB] clear with accept");
        applyStimulus(sparseBlk, 1'b1);
        waitIdle();
        checkOutput("clr_accept_flag_addr", 64'(lastFlagAddr), 64'd0);
        checkOutput("clr_accept_act_addr", 64'(firstActAddr), 64'd0);

        $display("[TB] act pointer wrap");
        applyStimulus(fullBlk, 1'b1);
        for (int b = 0; b < 30; b++) applyStimulus(fullBlk, 1'b0);
        applyStimulus(blk30, 1'b0);
        applyStimulus(sparseBlk, 1'b0);
        waitIdle();
        checkOutput("wrap_first_addr", 64'(firstActAddr), 64'h3FE);
        checkOutput("wrap_last_addr", 64'(lastActAddr), 64'h000);
        checkOutput("wrap_ptr_after", 64'(GBFACT_AddrWr), 64'h001);
        checkDrained("wrap");

        $display("[TB] random blocks");
        rdyMode = 1;
        for (int b = 0; b < 40; b++) begin
            rndBlk = '0;
            for (int i = 0; i < ND; i++) begin
                if ($urandom_range(0, 1) == 1) rndBlk = setElem(rndBlk, i, 8'($urandom_range(1, 255)));
            end
            applyStimulus(rndBlk, $urandom_range(0, 7) == 0);
        end
        waitIdle();
        checkDrained("random");
        rdyMode = 0;

        $display("[TB] reset mid-block");
        applyStimulus(fullBlk, 1'b0);
        repeat (5) tick();
        enterReset();
        tick();
        applyStimulus(sparseBlk, 1'b0);
        waitIdle();
        checkOutput("post_reset_flag_addr", 64'(lastFlagAddr), 64'd0);
        checkOutput("post_reset_act_addr", 64'(firstActAddr), 64'd0);
        checkDrained("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
